muldiv_unit: RTL and testbench



---
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operand/command and HI/LO result bundle between the datapath and the mul/div unit.
// Master drives the command side; slave returns HI/LO with busy/done status.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (output start, op, a, b, hi_we, lo_we, wd,
                    input  hi, lo, busy, done);
    modport slave  (input  start, op, a, b, hi_we, lo_we, wd,
                    output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; fixed WIDTH+1 cycle latency.
// No backpressure: commands and MTHI/MTLO are ignored while busy, so the caller stalls on busy.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     araw_q, araw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 divz_q, divz_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, div_part, div_trial;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiply keeps {partial product, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_abs     = a_neg ? -bus.a : bus.a;
        b_abs     = b_neg ? -bus.b : bus.b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_part  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_part - {1'b0, opnd_q};
        div_ge    = ~div_trial[WIDTH];

        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        araw_d    = araw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        ovf_d     = ovf_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d     = '0;
                    araw_d    = bus.a;
                    is_div_d  = bus.op[1];
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    divz_d    = bus.op[1] & (bus.b == '0);
                    ovf_d     = (bus.op == 2'b10) & (bus.a == MIN_NEG) & (&bus.b);
                    if (bus.op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_abs};
                        opnd_d = b_abs;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_abs};
                        opnd_d = a_abs;
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wd;
                    if (bus.lo_we) lo_d = bus.wd;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q)
                    acc_d = {(div_ge ? div_trial[WIDTH-1:0] : div_part[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge};
                else
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (divz_q) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else if (ovf_q) begin
                    hi_d = '0;
                    lo_d = araw_q;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            araw_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            ovf_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            araw_q    <= araw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            ovf_q     <= ovf_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table through a HI/LO scoreboard plus hand-built corner sequences.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) mif ();
    muldiv_unit #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    vec_t             vecs[12];
    logic [2*W-1:0]   sb_q[$];
    int               n_chk = 0;
    int               n_pass = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Called just after the launch edge (or mid-op); expects done lat cycles later.
    task automatic wait_done(input string nm, input int lat);
        int           n = 0;
        bit           ok = 1'b1;
        logic [W-1:0] h0 = mif.hi;
        logic [W-1:0] l0 = mif.lo;
        logic [2*W-1:0] e;
        while (!mif.done && n < 200) begin
            if (!mif.busy || mif.hi !== h0 || mif.lo !== l0) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, W'(n), W'(lat));
        chk({nm, " busy+hold"}, W'(ok), W'(1));
        if (mif.done) begin
            chk({nm, " busy at done"}, W'(mif.busy), W'(0));
            chk({nm, " scoreboard"}, W'(sb_q.size() != 0), W'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({nm, " hi"}, mif.hi, e[2*W-1:W]);
                chk({nm, " lo"}, mif.lo, e[W-1:0]);
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        @(negedge clk);
        mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
        sb_q.push_back({eh, el});
        @(posedge clk); #1;
        mif.start = 1'b0; mif.op = ~op; mif.a = $urandom; mif.b = $urandom;
        wait_done(nm, 33);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] hprev;
        int           dn;
        int           first_done;
        logic [2*W-1:0] e;

        vecs[0]  = '{"multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x5",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"div_m7d2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_by0",   2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_10d3",  2'b11, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003};
        vecs[6]  = '{"mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{"div_7dm2",   2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"multu_6x7",  2'b01, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
        vecs[9]  = '{"div_neg_by0",2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[10] = '{"mult_xm1",   2'b00, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};
        vecs[11] = '{"divu_maxd2", 2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF};

        rst_n = 1'b0;
        mif.start = 1'b0; mif.op = 2'b00; mif.a = '0; mif.b = '0;
        mif.hi_we = 1'b0; mif.lo_we = 1'b0; mif.wd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", mif.hi, '0);
        chk("reset lo", mif.lo, '0);
        chk("reset busy", W'(mif.busy), W'(0));
        chk("reset done", W'(mif.done), W'(0));
        @(negedge clk) rst_n = 1'b1;

        // MTHI and MTLO in the same idle cycle
        @(negedge clk);
        mif.hi_we = 1'b1; mif.lo_we = 1'b1; mif.wd = 32'hCAFEBABE;
        @(posedge clk); #1;
        mif.hi_we = 1'b0; mif.lo_we = 1'b0;
        chk("mthi", mif.hi, 32'hCAFEBABE);
        chk("mtlo", mif.lo, 32'hCAFEBABE);

        // start wins over a same-cycle MTLO
        @(negedge clk);
        mif.start = 1'b1; mif.op = 2'b11; mif.a = 32'd10; mif.b = 32'd3;
        mif.lo_we = 1'b1; mif.wd = 32'h00005555;
        sb_q.push_back({32'd1, 32'd3});
        @(posedge clk); #1;
        mif.start = 1'b0; mif.lo_we = 1'b0;
        chk("start+lo_we lo kept", mif.lo, 32'hCAFEBABE);
        chk("start+lo_we busy", W'(mif.busy), W'(1));
        wait_done("start+lo_we", 33);

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // start held for 40 cycles: exactly one op, relaunch right after done
        hprev = mif.hi;
        dn = 0;
        first_done = -1;
        @(negedge clk);
        mif.start = 1'b1; mif.op = 2'b11; mif.a = 32'd10; mif.b = 32'd3;
        sb_q.push_back({32'd1, 32'd3});
        sb_q.push_back({32'd1, 32'd3});
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin mif.hi_we = 1'b1; mif.wd = 32'h00001234; end
            if (c == 12) mif.hi_we = 1'b0;
            if (c == 6) chk("hi_we while busy", mif.hi, hprev);
            if (mif.done) begin
                dn++;
                if (first_done < 0) first_done = c;
                e = sb_q.pop_front();
                chk("held hi", mif.hi, e[2*W-1:W]);
                chk("held lo", mif.lo, e[W-1:0]);
            end
            if (c == 34) chk("held busy at done", W'(mif.busy), W'(0));
            if (c == 35) chk("held relaunch busy", W'(mif.busy), W'(1));
        end
        chk("held done count", W'(dn), W'(1));
        chk("held done cycle", W'(first_done), W'(34));
        mif.start = 1'b0;
        wait_done("held second", 28);

        // asynchronous reset mid-multiply discards the op
        @(negedge clk);
        mif.start = 1'b1; mif.op = 2'b00; mif.a = 32'h00012345; mif.b = 32'hFFFF0001;
        @(posedge clk); #1;
        mif.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst hi", mif.hi, '0);
        chk("async rst lo", mif.lo, '0);
        chk("async rst busy", W'(mif.busy), W'(0));
        chk("async rst done", W'(mif.done), W'(0));
        @(negedge clk) rst_n = 1'b1;
        run_op("post-reset multu", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
